// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: transfer sizes, master ids and default depth.
package sram_like_arbiter_pkg;

    localparam int ARB_DEPTH = 4;
    localparam int ARB_PTR_W = 2;
    localparam int N_MASTERS = 2;

    typedef enum logic [1:0] {
        SRAM_SIZE_B = 2'd0,
        SRAM_SIZE_H = 2'd1,
        SRAM_SIZE_W = 2'd2
    } sram_size_e;

    typedef enum logic {
        MASTER_DATA = 1'b0,
        MASTER_INST = 1'b1
    } master_e;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the two core-side sram-like ports (lane 0 = data, lane 1 = inst) and the merged slave port.
interface sram_like_arbiter_if;
    import sram_like_arbiter_pkg::*;

    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS-1:0]        m_wr;
    logic [N_MASTERS-1:0][1:0]   m_size;
    logic [N_MASTERS-1:0][3:0]   m_wstrb;
    logic [N_MASTERS-1:0][31:0]  m_addr;
    logic [N_MASTERS-1:0][31:0]  m_wdata;
    logic [N_MASTERS-1:0]        m_addr_ok;
    logic [N_MASTERS-1:0]        m_data_ok;
    logic [N_MASTERS-1:0][31:0]  m_rdata;

    logic                        s_req;
    logic                        s_wr;
    logic [1:0]                  s_size;
    logic [3:0]                  s_wstrb;
    logic [31:0]                 s_addr;
    logic [31:0]                 s_wdata;
    logic                        s_addr_ok;
    logic                        s_data_ok;
    logic [31:0]                 s_rdata;

    // The arbiter serves the core and the memory environment from the slave side.
    modport slave (
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
    );

    modport master (
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
    );

endinterface

// File: rtl/sram_like_arbiter_sync_id_fifo.sv
// In-order FIFO of master ids for accepted requests; push/pop take effect at the clock edge.
// Caller guarantees no push when full and no pop when empty.
module sync_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_DEPTH,
    parameter int PTR_W = ARB_PTR_W
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  master_e push_id_i,
    input  logic    pop_i,
    output master_e pop_id_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    master_e          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_id_i;
    end

    assign pop_id_o = mem_q[rd_ptr_q];
    assign full_o   = (cnt_q == FULL_CNT);
    assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges data/inst sram-like masters onto one slave port; data has fixed priority, zero-cycle addr_ok/data_ok.
// Stalls (s_req=0) while DEPTH requests are outstanding; an unaccepted request stays locked until taken.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_DEPTH,
    parameter int PTR_W = ARB_PTR_W
) (
    input  logic                clk,
    input  logic                reset,
    sram_like_arbiter_if.slave  bus
);

    master_e grant;
    logic    lock_vld_q, lock_vld_d;
    master_e lock_id_q, lock_id_d;
    logic    fifo_full, fifo_empty;
    logic    accept, retire;
    master_e retire_id;

    always_comb begin
        if (lock_vld_q)                   grant = lock_id_q;
        else if (bus.m_req[MASTER_DATA])  grant = MASTER_DATA;
        else                              grant = MASTER_INST;
    end

    // No bypass: a full FIFO blocks s_req even if an entry retires this cycle.
    assign bus.s_req   = bus.m_req[grant] & ~fifo_full;
    assign bus.s_wr    = bus.m_wr[grant];
    assign bus.s_size  = bus.m_size[grant];
    assign bus.s_wstrb = bus.m_wstrb[grant];
    assign bus.s_addr  = bus.m_addr[grant];
    assign bus.s_wdata = bus.m_wdata[grant];

    assign accept = bus.s_req & bus.s_addr_ok;
    assign retire = bus.s_data_ok & ~fifo_empty;

    always_comb begin
        bus.m_addr_ok        = '0;
        bus.m_data_ok        = '0;
        bus.m_rdata          = '0;
        bus.m_addr_ok[grant] = accept;
        if (retire) begin
            bus.m_data_ok[retire_id] = 1'b1;
            bus.m_rdata[retire_id]   = bus.s_rdata;
        end
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (accept) begin
            lock_vld_d = 1'b0;
        end else if (bus.s_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= MASTER_DATA;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    sync_id_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (accept),
        .push_id_i (grant),
        .pop_i     (retire),
        .pop_id_o  (retire_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // A locked master must keep requesting until its request is accepted.
    lock_hold_a: assert property (@(posedge clk) disable iff (reset)
        lock_vld_q |-> bus.m_req[lock_id_q]);

endmodule
